// File: rtl/pll_reset_sequencer.sv
// Purpose: staged reset release behind the PLL. The raw lock flag is
// synchronised into clk, lock must stay stable for LOCK_STABLE_CYCLES, then
// sys_rst_n releases, and CORE_DELAY cycles later core_rst_n/ready release.
// Any loss of lock after release re-asserts both resets and is counted.
// Ports:
//   clk           PLL output clock, rising edge
//   rst_n         asynchronous active-low reset
//   pll_lock      raw PLL lock flag (asynchronous to clk)
//   sys_rst_n     registered active-low reset, memories/peripherals
//   core_rst_n    registered active-low reset, processor core
//   ready         registered copy of core_rst_n
//   state         current FSM state (WAIT_LOCK=0 STABLE=1 RELEASE=2 RUN=3)
//   lock_loss_cnt saturating count of lock losses from RELEASE or RUN
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned CORE_DELAY         = 16,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       sys_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned LOSS_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CORE_LAST   = CNT_WIDTH'(CORE_DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LOSS_W-1:0]      loss_d;
    logic                   loss_event;
    logic                   sys_d, core_d;

    // Lock synchroniser; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            sys_rst_n     <= 1'b0;
            core_rst_n    <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sys_rst_n     <= sys_d;
            core_rst_n    <= core_d;
            ready         <= core_d;
            lock_loss_cnt <= loss_d;
        end
    end

    assign state = state_q;

    // Next state, counter and loss accounting; outputs decode the next state
    // so both resets change on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else if (cnt_q == CORE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        loss_d = lock_loss_cnt;
        if (loss_event && (lock_loss_cnt != '1)) begin
            loss_d = lock_loss_cnt + LOSS_W'(1);
        end

        sys_d  = (state_d == RELEASE) || (state_d == RUN);
        core_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2,
// LOCK_STABLE_CYCLES=8, CORE_DELAY=4. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       sys_rst_n;
    logic       core_rst_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .CORE_DELAY        (4),
        .CNT_WIDTH         (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .sys_rst_n    (sys_rst_n),
        .core_rst_n   (core_rst_n),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one rising edge and move to the sampling point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core never out of reset while sys is held.
    always @(negedge clk) chk("order", 32'(core_rst_n & ~sys_rst_n), 32'd0);

    // Full sequence measured from the first edge after lock (or reset release)
    // with the synchroniser cleared: STABLE at edge 3, RELEASE at 11, RUN at 15.
    task automatic run_seq(input string tag, input int unsigned loss_exp);
        logic [1:0] st;
        for (int k = 1; k <= 15; k++) begin
            tick();
            st = (k < 3) ? 2'd0 : (k < 11) ? 2'd1 : (k < 15) ? 2'd2 : 2'd3;
            chk($sformatf("%s_state_e%0d", tag, k), 32'(state), 32'(st));
            chk($sformatf("%s_sys_e%0d", tag, k), 32'(sys_rst_n), 32'(k >= 11));
            chk($sformatf("%s_core_e%0d", tag, k), 32'(core_rst_n), 32'(k >= 15));
            chk($sformatf("%s_ready_e%0d", tag, k), 32'(ready), 32'(k >= 15));
        end
        chk($sformatf("%s_loss", tag), 32'(lock_loss_cnt), 32'(loss_exp));
    endtask

    // Hold reset for a few cycles then release just before a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sys", 32'(sys_rst_n), 32'd0);
        chk("rst_core", 32'(core_rst_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_loss", 32'(lock_loss_cnt), 32'd0);
        rst_n = 1'b1;
    endtask

    // Drop lock from RUN for 5 cycles; resets fall 3 edges after the drop.
    task automatic loss_from_run(input string tag, input int unsigned loss_exp);
        @(negedge clk);
        pll_lock = 1'b0;
        tick();
        tick();
        chk({tag, "_sys_hold"}, 32'(sys_rst_n), 32'd1);
        tick();
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_sys"}, 32'(sys_rst_n), 32'd0);
        chk({tag, "_core"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_loss"}, 32'(lock_loss_cnt), 32'(loss_exp));
        tick();
        tick();
        @(negedge clk);
        pll_lock = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        #1;
        chk("por_state", 32'(state), 32'd0);
        chk("por_sys", 32'(sys_rst_n), 32'd0);

        // 1: basic power-up sequence
        @(negedge clk);
        do_reset();
        run_seq("s1", 0);

        // 2: lock glitch while STABLE at cnt=5
        @(negedge clk);
        do_reset();
        for (int k = 1; k <= 8; k++) tick();
        chk("s2_state_e8", 32'(state), 32'd1);
        @(negedge clk);
        pll_lock = 1'b0;
        for (int k = 9; k <= 12; k++) begin
            tick();
            chk($sformatf("s2_sys_e%0d", k), 32'(sys_rst_n), 32'd0);
            if (k == 11) chk("s2_state_e11", 32'(state), 32'd0);
        end
        @(negedge clk);
        pll_lock = 1'b1;
        run_seq("s2", 0);

        // 3: lock loss from RUN, then full re-sequence
        loss_from_run("s3", 1);
        run_seq("s3r", 1);

        // 4: lock_s low while RELEASE holds cnt=2
        @(negedge clk);
        do_reset();
        for (int k = 1; k <= 11; k++) tick();
        chk("s4_state_e11", 32'(state), 32'd2);
        @(negedge clk);
        pll_lock = 1'b0;
        tick();
        tick();
        chk("s4_state_e13", 32'(state), 32'd2);
        chk("s4_core_e13", 32'(core_rst_n), 32'd0);
        tick();
        chk("s4_state_e14", 32'(state), 32'd0);
        chk("s4_sys_e14", 32'(sys_rst_n), 32'd0);
        chk("s4_core_e14", 32'(core_rst_n), 32'd0);
        chk("s4_loss_e14", 32'(lock_loss_cnt), 32'd1);
        tick();
        @(negedge clk);
        pll_lock = 1'b1;
        run_seq("s4r", 1);

        // 5: asynchronous reset pulse mid-RUN, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_state", 32'(state), 32'd0);
        chk("s5_sys", 32'(sys_rst_n), 32'd0);
        chk("s5_core", 32'(core_rst_n), 32'd0);
        chk("s5_ready", 32'(ready), 32'd0);
        chk("s5_loss", 32'(lock_loss_cnt), 32'd0);
        #4;
        rst_n = 1'b1;
        run_seq("s5r", 0);

        // 6: saturation of the loss counter
        for (int i = 1; i <= 260; i++) begin
            loss_from_run($sformatf("s6_%0d", i), (i > 255) ? 255 : i);
            for (int k = 1; k <= 15; k++) tick();
            chk($sformatf("s6_run_%0d", i), 32'(state), 32'd3);
        end
        chk("s6_final_loss", 32'(lock_loss_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
